// File: rtl/tag_release_buffer_pkg.sv
// Shared types and sizing helpers for the tag release buffer slice.
package tag_pkg;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned QDEPTH = 16;

  // Width of a scalar tag able to name every one of 'depth' tags.
  function automatic int unsigned tag_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned TAG_W  = tag_width(DEPTH);
  localparam int unsigned QPTR_W = $clog2(QDEPTH);

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [QPTR_W-1:0] qptr_t;

endpackage

// File: rtl/tag_release_buffer_lane_compact.sv
// Lane compactor: packs the data of active (low) strobes toward lane 0 in lane
// order, and reports each lane's prefix-sum offset and the active-lane count.
module lane_compact #(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = 4,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         strb_n,
  input  logic [N-1:0][W-1:0]  data_i,
  output logic [N-1:0][CW-1:0] offs_o,
  output logic [N-1:0][W-1:0]  comp_o,
  output logic [CW-1:0]        cnt_o
);

  logic [CW-1:0] acc;

  // Running prefix count; each active lane lands in the slot equal to its offset.
  always_comb begin
    acc    = '0;
    offs_o = '0;
    comp_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      offs_o[i] = acc;
      if (!strb_n[i]) begin
        for (int unsigned j = 0; j < N; j++) begin
          if (acc == CW'(j)) comp_o[j] = data_i[i];
        end
        acc = acc + CW'(1);
      end
    end
    cnt_o = acc;
  end

endmodule

// File: rtl/tag_release_buffer.sv
// Tag release buffer: elastic circular queue between the commit release lanes
// and the free-list write ports. Holds released tags while the free list is
// busy and drains up to WRITE tags per non-busy cycle in arrival order.
// Optional same-cycle bypass when empty: define TAG_RELEASE_BYPASS_EN.
module tag_release_buffer
  import tag_pkg::*;
#(
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned IN     = 4,
  parameter  int unsigned WRITE  = 4,
  parameter  int unsigned QDEPTH = 16,
  localparam int unsigned TAG    = tag_width(DEPTH),
  localparam int unsigned PW     = $clog2(QDEPTH),
  localparam int unsigned CW     = PW + 1,
  localparam int unsigned NW     = $clog2(IN + 1)
) (
  input  logic                      clk,
  input  logic                      reset_,
  input  logic                      flush_,
  input  logic [IN-1:0]             rel_,
  input  logic [IN-1:0][TAG-1:0]    rel_tag,
  output logic                      ready,
  input  logic                      fl_busy,
  output logic [WRITE-1:0]          fl_we_,
  output logic [WRITE-1:0][TAG-1:0] fl_wd,
  output logic [CW-1:0]             count,
  output logic                      empty,
  output logic                      ovf
);

  logic [TAG-1:0]          mem_q [QDEPTH];
  logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic [CW-1:0]           nv, nd, nb, nenq;
  logic                    ready_c, enq_ok, byp;
  logic [IN-1:0][NW-1:0]   offs;
  logic [IN-1:0][TAG-1:0]  comp;
  logic [NW-1:0]           pop;

  lane_compact #(
    .N (IN),
    .W (TAG)
  ) u_rel_compact (
    .strb_n (rel_),
    .data_i (rel_tag),
    .offs_o (offs),
    .comp_o (comp),
    .cnt_o  (pop)
  );

  assign nv      = CW'(pop);
  assign ready_c = (CW'(QDEPTH) - count_q) >= CW'(IN);
  assign enq_ok  = flush_ && ready_c;
  assign nd      = (flush_ && !fl_busy)
                 ? ((count_q < CW'(WRITE)) ? count_q : CW'(WRITE)) : '0;

`ifdef TAG_RELEASE_BYPASS_EN
  assign byp = reset_ && flush_ && !fl_busy && (count_q == '0) && ready_c;
`else
  logic unused_comp;
  assign byp         = 1'b0;
  assign unused_comp = ^comp;
`endif

  // Tags taken by the bypass path are not written into storage.
  assign nb   = byp ? ((nv < CW'(WRITE)) ? nv : CW'(WRITE)) : '0;
  assign nenq = enq_ok ? (nv - nb) : '0;

  assign ready = ready_c;
  assign count = count_q;
  assign empty = (count_q == '0);
  assign ovf   = ovf_q;

  // Free-list write lanes: queued tags from head first, else bypassed releases.
  always_comb begin
    fl_we_ = '1;
    fl_wd  = '0;
    for (int unsigned w = 0; w < WRITE; w++) begin
      if (CW'(w) < nd) begin
        fl_we_[w] = 1'b0;
        fl_wd[w]  = mem_q[head_q + PW'(w)];
      end
`ifdef TAG_RELEASE_BYPASS_EN
      else if ((w < IN) && (CW'(w) < nb)) begin
        fl_we_[w] = 1'b0;
        fl_wd[w]  = comp[w];
      end
`endif
    end
  end

  // Pointer/count/overflow next state; flush wins over everything else.
  // A dropped (overflowing) release still lets the dequeue proceed, since the
  // free list has already consumed the tags presented on its write lanes.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (!flush_) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      head_d  = head_q + PW'(nd);
      tail_d  = tail_q + PW'(nenq);
      count_d = count_q + nenq - nd;
      if (!ready_c && (nv != '0)) ovf_d = 1'b1;
    end
  end

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage write: each active lane scatters to tail plus its compacted offset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < IN; i++) begin
      if (enq_ok && !rel_[i] && (CW'(offs[i]) >= nb)) begin
        mem_q[tail_q + PW'(CW'(offs[i]) - nb)] <= rel_tag[i];
      end
    end
  end

endmodule

// File: tb/tb_tag_release_buffer.sv
// Self-checking bench for tag_release_buffer against a queue-based model.
module tb_tag_release_buffer;
  import tag_pkg::*;

  localparam int DEPTH  = 16;
  localparam int IN     = 4;
  localparam int WRITE  = 4;
  localparam int QDEPTH = 16;
  localparam int TAG    = $clog2(DEPTH);
  localparam int CW     = $clog2(QDEPTH) + 1;
`ifdef TAG_RELEASE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset_, flush_, fl_busy, ready, empty, ovf;
  logic [IN-1:0]             rel_;
  logic [IN-1:0][TAG-1:0]    rel_tag;
  logic [WRITE-1:0]          fl_we_;
  logic [WRITE-1:0][TAG-1:0] fl_wd;
  logic [CW-1:0]             count;

  logic [WRITE-1:0]          ewe;
  logic [WRITE-1:0][TAG-1:0] ewd;

  int errors = 0;
  int checks = 0;
  int mq[$];
  bit movf;

  always #5 clk = ~clk;

  tag_release_buffer #(
    .DEPTH  (DEPTH),
    .IN     (IN),
    .WRITE  (WRITE),
    .QDEPTH (QDEPTH)
  ) dut (
    .clk     (clk),
    .reset_  (reset_),
    .flush_  (flush_),
    .rel_    (rel_),
    .rel_tag (rel_tag),
    .ready   (ready),
    .fl_busy (fl_busy),
    .fl_we_  (fl_we_),
    .fl_wd   (fl_wd),
    .count   (count),
    .empty   (empty),
    .ovf     (ovf)
  );

  function automatic bit m_ready();
    return (QDEPTH - mq.size()) >= IN;
  endfunction

  // Expected write lanes for the current inputs and model contents.
  function automatic void model_out(output logic [WRITE-1:0] we,
                                    output logic [WRITE-1:0][TAG-1:0] wd);
    int act[$];
    we = '1;
    wd = '0;
    if (!flush_ || fl_busy) return;
    if (mq.size() == 0) begin
      if (BYP) begin
        for (int i = 0; i < IN; i++) if (!rel_[i]) act.push_back(int'(rel_tag[i]));
        for (int w = 0; w < WRITE && w < act.size(); w++) begin
          we[w] = 1'b0;
          wd[w] = TAG'(act[w]);
        end
      end
      return;
    end
    for (int w = 0; w < WRITE && w < mq.size(); w++) begin
      we[w] = 1'b0;
      wd[w] = TAG'(mq[w]);
    end
  endfunction

  // Model state change at the clock edge for the current inputs.
  function automatic void model_edge();
    int act[$];
    int nd;
    bit rdy;
    if (!flush_) begin
      mq.delete();
      movf = 1'b0;
      return;
    end
    rdy = m_ready();
    for (int i = 0; i < IN; i++) if (!rel_[i]) act.push_back(int'(rel_tag[i]));
    nd = fl_busy ? 0 : ((mq.size() < WRITE) ? mq.size() : WRITE);
    if (BYP && !fl_busy && mq.size() == 0 && rdy) begin
      for (int k = 0; k < WRITE && act.size() > 0; k++) void'(act.pop_front());
    end
    repeat (nd) void'(mq.pop_front());
    if (act.size() > 0) begin
      if (!rdy) movf = 1'b1;
      else foreach (act[k]) mq.push_back(act[k]);
    end
  endfunction

  task automatic test_reset();
    reset_ = 1'b0; flush_ = 1'b1; fl_busy = 1'b0; rel_ = '1; rel_tag = '0;
    mq.delete(); movf = 1'b0;
    #3;
    checks++;
    if (count !== '0 || empty !== 1'b1 || ovf !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: count=%0d empty=%b ovf=%b ready=%b expected 0 1 0 1",
               count, empty, ovf, ready);
    end
    checks++;
    if (fl_we_ !== '1 || fl_wd !== '0) begin
      errors++;
      $display("FAIL reset_lanes: fl_we_=%b fl_wd=%h expected 1111 0", fl_we_, fl_wd);
    end
    @(posedge clk); #1;
    reset_ = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sparse();
    logic [IN-1:0] pat [2];
    pat[0] = 4'b1010; pat[1] = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      rel_ = (c < 2) ? pat[c] : '1;
      rel_tag[0] = 3; rel_tag[1] = 14; rel_tag[2] = 9; rel_tag[3] = 5;
      fl_busy = 1'b0;
      #1;
      model_out(ewe, ewd);
      checks++;
      if (fl_we_ !== ewe || fl_wd !== ewd) begin
        errors++;
        $display("FAIL sparse_out c%0d: fl_we_=%b fl_wd=%h expected %b %h", c, fl_we_, fl_wd, ewe, ewd);
      end
`ifndef TAG_RELEASE_BYPASS_EN
      if (c == 1) begin
        checks++;
        if (fl_we_ !== 4'b1100 || fl_wd[0] !== 4'd3 || fl_wd[1] !== 4'd9) begin
          errors++;
          $display("FAIL sparse_const: fl_we_=%b wd0=%0d wd1=%0d expected 1100 3 9",
                   fl_we_, fl_wd[0], fl_wd[1]);
        end
      end
`endif
      model_edge();
      @(posedge clk); #1;
      checks++;
      if (count !== CW'(mq.size())) begin
        errors++;
        $display("FAIL sparse_count c%0d: count=%0d expected %0d", c, count, mq.size());
      end
    end
  endtask

  task automatic test_busy_burst();
    for (int c = 0; c < 4; c++) begin
      fl_busy = (c < 2);
      rel_ = (c < 2) ? '0 : '1;
      for (int i = 0; i < IN; i++) rel_tag[i] = TAG'(c * 4 + i);
      #1;
      model_out(ewe, ewd);
      if (c < 2) begin
        checks++;
        if (fl_we_ !== 4'b1111) begin
          errors++;
          $display("FAIL busy_hold c%0d: fl_we_=%b expected 1111", c, fl_we_);
        end
      end else begin
        checks++;
        if (fl_we_ !== 4'b0000 || fl_wd !== ewd) begin
          errors++;
          $display("FAIL busy_drain c%0d: fl_we_=%b fl_wd=%h expected 0000 %h", c, fl_we_, fl_wd, ewd);
        end
      end
      model_edge();
      @(posedge clk); #1;
      if (c == 1) begin
        checks++;
        if (count !== 5'd8) begin
          errors++;
          $display("FAIL busy_count: count=%0d expected 8", count);
        end
      end
    end
    checks++;
    if (count !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL busy_empty: count=%0d empty=%b expected 0 1", count, empty);
    end
  endtask

  task automatic test_overflow();
    logic [IN-1:0] pat [5];
    pat[0] = 4'b0000; pat[1] = 4'b0000; pat[2] = 4'b0000; pat[3] = 4'b1110; pat[4] = 4'b0001;
    fl_busy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      rel_ = pat[c];
      for (int i = 0; i < IN; i++) rel_tag[i] = TAG'($urandom_range(0, DEPTH - 1));
      #1;
      if (c == 4) begin
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL ovf_ready: ready=%b expected 0 at count %0d", ready, count);
        end
      end
      model_edge();
      @(posedge clk); #1;
    end
    checks++;
    if (ovf !== 1'b1 || count !== 5'd13 || movf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b count=%0d expected 1 13", ovf, count);
    end
    flush_ = 1'b0; fl_busy = 1'b0; rel_ = '0;
    #1;
    checks++;
    if (fl_we_ !== '1) begin
      errors++;
      $display("FAIL ovf_flush_lanes: fl_we_=%b expected 1111", fl_we_);
    end
    model_edge();
    @(posedge clk); #1;
    flush_ = 1'b1; rel_ = '1;
    checks++;
    if (ovf !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b count=%0d expected 0 0", ovf, count);
    end
  endtask

  task automatic test_flush();
    fl_busy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      rel_ = (c == 0) ? 4'b0000 : 4'b1110;
      for (int i = 0; i < IN; i++) rel_tag[i] = TAG'(i + 1);
      #1; model_edge();
      @(posedge clk); #1;
    end
    checks++;
    if (count !== 5'd5) begin
      errors++;
      $display("FAIL flush_fill: count=%0d expected 5", count);
    end
    flush_ = 1'b0; fl_busy = 1'b0; rel_ = '0;
    #1;
    checks++;
    if (fl_we_ !== '1) begin
      errors++;
      $display("FAIL flush_lanes: fl_we_=%b expected 1111", fl_we_);
    end
    model_edge();
    @(posedge clk); #1;
    flush_ = 1'b1; rel_ = '1;
    #1;
    checks++;
    if (count !== '0 || empty !== 1'b1 || ovf !== 1'b0 || fl_we_ !== '1) begin
      errors++;
      $display("FAIL flush_after: count=%0d empty=%b ovf=%b fl_we_=%b expected 0 1 0 1111",
               count, empty, ovf, fl_we_);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [IN-1:0] pat [7];
    pat[0] = 4'b0000; pat[1] = 4'b0000; pat[2] = 4'b0000; pat[3] = 4'b1100;
    pat[4] = 4'b1111; pat[5] = 4'b0000; pat[6] = 4'b1111;
    fl_busy = 1'b0;
    for (int c = 0; c < 7; c++) begin
      rel_ = pat[c];
      for (int i = 0; i < IN; i++) rel_tag[i] = (c == 5) ? TAG'(10 + i) : TAG'($urandom_range(0, DEPTH - 1));
      #1;
      model_out(ewe, ewd);
      checks++;
      if (fl_we_ !== ewe || fl_wd !== ewd) begin
        errors++;
        $display("FAIL wrap_out c%0d: fl_we_=%b fl_wd=%h expected %b %h", c, fl_we_, fl_wd, ewe, ewd);
      end
`ifndef TAG_RELEASE_BYPASS_EN
      if (c == 6) begin
        checks++;
        if (fl_we_ !== 4'b0000 || fl_wd[0] !== 4'd10 || fl_wd[1] !== 4'd11 ||
            fl_wd[2] !== 4'd12 || fl_wd[3] !== 4'd13) begin
          errors++;
          $display("FAIL wrap_order: fl_we_=%b fl_wd=%h expected 0000 dcba", fl_we_, fl_wd);
        end
      end
`endif
      model_edge();
      @(posedge clk); #1;
    end
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL wrap_count: count=%0d expected 0", count);
    end
  endtask

`ifdef TAG_RELEASE_BYPASS_EN
  task automatic test_bypass();
    fl_busy = 1'b0; rel_ = 4'b0011;
    rel_tag[0] = 1; rel_tag[1] = 2; rel_tag[2] = 7; rel_tag[3] = 8;
    #1;
    checks++;
    if (fl_we_ !== 4'b1100 || fl_wd[0] !== 4'd7 || fl_wd[1] !== 4'd8) begin
      errors++;
      $display("FAIL bypass_out: fl_we_=%b wd0=%0d wd1=%0d expected 1100 7 8", fl_we_, fl_wd[0], fl_wd[1]);
    end
    model_edge();
    @(posedge clk); #1;
    rel_ = '1;
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL bypass_count: count=%0d expected 0", count);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      fl_busy = ($urandom_range(0, 9) < 4);
      flush_  = ($urandom_range(0, 59) != 0);
      rel_    = m_ready() ? IN'($urandom) : '1;
      for (int i = 0; i < IN; i++) rel_tag[i] = TAG'($urandom_range(0, DEPTH - 1));
      #1;
      model_out(ewe, ewd);
      checks++;
      if (fl_we_ !== ewe || fl_wd !== ewd || ready !== m_ready()) begin
        errors++;
        $display("FAIL rand_out c%0d: fl_we_=%b fl_wd=%h ready=%b expected %b %h %b",
                 c, fl_we_, fl_wd, ready, ewe, ewd, m_ready());
      end
      model_edge();
      @(posedge clk); #1;
      checks++;
      if (count !== CW'(mq.size()) || empty !== (mq.size() == 0) || ovf !== movf) begin
        errors++;
        $display("FAIL rand_state c%0d: count=%0d empty=%b ovf=%b expected %0d %b %b",
                 c, count, empty, ovf, mq.size(), mq.size() == 0, movf);
      end
    end
    flush_ = 1'b1; rel_ = '1;
  endtask

  task automatic test_midreset();
    fl_busy = 1'b1; rel_ = '0;
    for (int i = 0; i < IN; i++) rel_tag[i] = TAG'(i + 1);
    #1; model_edge();
    @(posedge clk); #1;
    rel_ = '1; fl_busy = 1'b0;
    #2;
    reset_ = 1'b0;
    mq.delete(); movf = 1'b0;
    #1;
    checks++;
    if (count !== '0 || empty !== 1'b1 || fl_we_ !== '1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset: count=%0d empty=%b fl_we_=%b ready=%b expected 0 1 1111 1",
               count, empty, fl_we_, ready);
    end
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_busy_burst();
    test_overflow();
    test_flush();
    test_wrap();
`ifdef TAG_RELEASE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
